// File: rtl/store_buffer.sv
// store_buffer: write buffer between the CPU MEM stage and DataMemory.
// It accepts stores into a small FIFO and retires them to DataMemory on
// cycles when the CPU is not using the memory port. Loads are answered in
// the same cycle, and buffered data is forwarded so a load always sees the
// newest stored value.
//
// Ports:
//   Clock, ResetN                     clock (rising edge), async active-low reset
//   CpuAddress/CpuWriteData           MEM-stage address and store data
//   CpuMemWrite/CpuMemRead            store / load request (mutually exclusive)
//   CpuReadData                       load result (combinational)
//   Stall                             store refused this cycle (buffer full)
//   Empty                             no buffered stores
//   MemAddress/MemWriteData/MemWrite/MemRead  drive DataMemory
//   MemReadData                       DataMemory combinational read data
module store_buffer #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 24,
   parameter int DATA_WIDTH = 24
) (
   input  logic                  Clock,
   input  logic                  ResetN,
   input  logic [ADDR_WIDTH-1:0] CpuAddress,
   input  logic [DATA_WIDTH-1:0] CpuWriteData,
   input  logic                  CpuMemWrite,
   input  logic                  CpuMemRead,
   output logic [DATA_WIDTH-1:0] CpuReadData,
   output logic                  Stall,
   output logic                  Empty,
   output logic [ADDR_WIDTH-1:0] MemAddress,
   output logic [DATA_WIDTH-1:0] MemWriteData,
   output logic                  MemWrite,
   output logic                  MemRead,
   input  logic [DATA_WIDTH-1:0] MemReadData
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_q [DEPTH];
   logic [DEPTH-1:0]      valid_q, valid_d;
   logic [PW-1:0]         head_q, head_d;
   logic [PW-1:0]         tail_q, tail_d;
   logic [PW:0]           count_q, count_d;

   logic                  full, push, drain;
   logic                  fwd_hit;
   logic [DATA_WIDTH-1:0] fwd_data;
   logic [PW-1:0]         idx;

   // Push and drain are mutually exclusive by construction: push needs a
   // store with room, drain needs no store or a full buffer.
   always_comb begin
      full  = (count_q == FULL_CNT);
      Empty = (count_q == '0);
      push  = CpuMemWrite && !full;
      drain = !Empty && !CpuMemRead && (!CpuMemWrite || full);
      Stall = CpuMemWrite && full;
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      valid_d = valid_q;
      if (push) begin
         valid_d[tail_q] = 1'b1;
         tail_d          = tail_q + 1'b1;
         count_d         = count_q + 1'b1;
      end else if (drain) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + 1'b1;
         count_d         = count_q - 1'b1;
      end
   end

   // Walk from oldest (head) to youngest; the last hit wins, giving the
   // youngest matching entry.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      idx      = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head_q + PW'(i);
         if (valid_q[idx] && (addr_q[idx] == CpuAddress)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[idx];
         end
      end
   end

   always_comb begin
      MemAddress   = '0;
      MemWriteData = '0;
      MemWrite     = 1'b0;
      MemRead      = 1'b0;
      CpuReadData  = '0;
      if (CpuMemRead) begin
         MemRead     = 1'b1;
         MemAddress  = CpuAddress;
         CpuReadData = fwd_hit ? fwd_data : MemReadData;
      end else if (drain) begin
         MemWrite     = 1'b1;
         MemAddress   = addr_q[head_q];
         MemWriteData = data_q[head_q];
      end
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
         if (push) begin
            addr_q[tail_q] <= CpuAddress;
            data_q[tail_q] <= CpuWriteData;
         end
      end
   end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-buffer stage between the CPU MEM stage and DataMemory.
- Accepts 24-bit stores from the pipeline into a small FIFO. Retires them to DataMemory on cycles the CPU is not using the memory port.
- Loads are serviced immediately. Data still held in the buffer is forwarded so every load sees the newest value.
- Owns DataMemory's Address/WriteData/MemWrite/MemRead inputs and consumes its ReadData.

Parameters:
DEPTH, 4, number of buffered stores (power of two, >=2)
ADDR_WIDTH, 24, address width
DATA_WIDTH, 24, data width

Ports:
Clock  input  1  system clock, rising edge
ResetN  input  1  asynchronous active-low reset
CpuAddress  input  ADDR_WIDTH  load/store address from MEM stage
CpuWriteData  input  DATA_WIDTH  store data
CpuMemWrite  input  1  store request
CpuMemRead  input  1  load request (never asserted together with CpuMemWrite)
CpuReadData  output  DATA_WIDTH  load result, combinational
Stall  output  1  store not accepted this cycle; CPU holds request
Empty  output  1  buffer holds no stores
MemAddress  output  ADDR_WIDTH  to DataMemory Address
MemWriteData  output  DATA_WIDTH  to DataMemory WriteData
MemWrite  output  1  to DataMemory MemWrite
MemRead  output  1  to DataMemory MemRead
MemReadData  input  DATA_WIDTH  from DataMemory ReadData (combinational read)

Behaviour:
- Interface: one clock (Clock); reset is asynchronous and active-low (ResetN).
- DataMemory contract:
  - Writes on the Clock rising edge when MemWrite=1.
  - MemReadData is valid in the same cycle as MemRead=1.
- State:
  - DEPTH entries of {addr, data, valid}.
  - head and tail pointers, log2(DEPTH) bits each, wrapping modulo DEPTH.
  - count register, log2(DEPTH)+1 bits.
- Reset (async, immediate while ResetN=0):
  - head=tail=count=0; all valid=0.
  - Resulting outputs: Empty=1, Stall=0, MemWrite=0, MemRead=0, MemAddress=0, MemWriteData=0, CpuReadData=0.
- full = (count==DEPTH); Empty = (count==0).
- drain (combinational) = !Empty && !CpuMemRead && (!CpuMemWrite || full).
- Push (store accept):
  - Condition: CpuMemWrite && !full.
  - At the edge, {CpuAddress, CpuWriteData} is written at tail, valid set, tail+1, count+1.
  - Stall = CpuMemWrite && full (combinational). The store is not pushed; the CPU retries next cycle.
- Drain:
  - When drain=1: MemWrite=1, MemAddress=head.addr, MemWriteData=head.data.
  - At the edge: head.valid cleared, head+1, count-1.
  - Full + store: drain and Stall are both 1; the slot frees and the retried store pushes next cycle.
  - Push and pop never occur in the same cycle.
- Load:
  - When CpuMemRead=1: MemRead=1, MemAddress=CpuAddress, MemWrite=0. No drain that cycle.
  - Forwarding: compare CpuAddress against every valid entry with a full-width compare. If any match, CpuReadData = data of the youngest matching entry, meaning the one nearest tail-1 walking backwards. Otherwise CpuReadData = MemReadData.
  - Load latency is 0 cycles (same cycle). Loads never stall.
- Idle (no read, no drain): MemRead=0, MemWrite=0, MemAddress=0, MemWriteData=0. CpuReadData=0 whenever CpuMemRead=0.
- Duplicate addresses may coexist in the buffer. They drain in FIFO order, so the final memory value equals the last store.
- Reset mid-operation: buffered stores are discarded and not written. Any MemWrite asserted is deasserted immediately.
- Pointer wrap: tail DEPTH-1 -> 0 and head DEPTH-1 -> 0 with no loss of entries.

Test Plan:
- Reset then idle: ResetN=0 with stores pending -> Empty=1, MemWrite=0, count=0 after release; memory word 16 unchanged.
- Single store then idle: store addr 16 data 2, next cycle no access -> MemWrite=1, MemAddress=16, MemWriteData=2 for one cycle; Empty=1 after; DataMemory[16]=2.
- Forwarding:
  - Store 10<-5, then store 10<-7, then load 10 with no idle cycles -> CpuReadData=7 while MemReadData shows the old memory value.
  - Load 12 (unbuffered) -> CpuReadData=DataMemory[12].
- Full/stall: DEPTH=4, five back-to-back stores to 0..4 (data 100..104):
  - 5th cycle: Stall=1, MemWrite=1, MemAddress=0.
  - 6th cycle: store 4 accepted, Stall=0.
  - After idle drain: memory 0..4 = 100..104.
- Load blocks drain: buffer holds 1 entry, CpuMemRead=1 for 3 cycles -> MemWrite=0 throughout, MemRead=1; drain occurs on the first non-load cycle.
- Wrap-around: 10 interleaved store/idle pairs -> pointers wrap twice; every store reaches memory in order; Empty=1 at end.
